// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pll_reset_sequencer                                        |
// | Description : Brings up the 72 MHz core PLL from the 50 MHz reference    |
// |               domain. Pulses the PLL reset, waits for a synchronized     |
// |               lock, qualifies it over a stability window, then releases  |
// |               the core reset and, a fixed gap later, the video reset.    |
// |               Lock loss or a restart request re-runs the sequence.       |
// | Option      : PLLSEQ_RETRY_LIMIT_EN - when defined, the sequencer parks  |
// |               in FAIL after MAX_RETRIES lock timeouts; otherwise it      |
// |               retries forever and fail is constant 0.                    |
// | Ports       : clk, rst          reference clock, sync active-high reset  |
// |               restart_req       1-cycle pulse, restart whole sequence    |
// |               pll_locked        PLL lock, asynchronous to clk            |
// |               pll_rst           reset to PLL wrapper                     |
// |               rst_core          core reset (active-high)                 |
// |               rst_video         video reset (active-high)                |
// |               ready, fail       RUN / FAIL state indicators              |
// |               retry_cnt[3:0]    failed lock attempts, saturating at 15   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65535,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGE_GAP      = 16,
  parameter int unsigned MAX_RETRIES    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_req,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       rst_core,
  output logic       rst_video,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
);

`ifdef PLLSEQ_RETRY_LIMIT_EN
  localparam bit RETRY_LIMIT_EN = 1'b1;
`else
  localparam bit RETRY_LIMIT_EN = 1'b0;
`endif

  // Counter is sized for the longest timed state.
  localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int          CNT_W  = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_STAGE     = 3'd3,
    S_RUN       = 3'd4,
    S_LOST      = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       retry_next;
  logic [4:0]       retry_p1;
  logic [3:0]       retry_sat;
  logic [1:0]       lock_sync;
  logic             lock_s;

  assign lock_s    = lock_sync[1];
  assign retry_p1  = {1'b0, retry_cnt} + 5'd1;
  assign retry_sat = retry_p1[4] ? 4'hF : retry_p1[3:0];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    retry_next = retry_cnt;

    unique case (state)
      S_PLL_RST: begin
        if (cnt == PLL_RST_LAST) state_next = S_WAIT_LOCK;
        else                     cnt_next   = cnt + CNT_W'(1);
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_next = retry_sat;
          // Unsaturated attempt count so the limit test never aliases.
          if (RETRY_LIMIT_EN && (32'(retry_p1) >= MAX_RETRIES)) state_next = S_FAIL;
          else                                                  state_next = S_PLL_RST;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // A single unlocked sample restarts qualification; not a failed attempt.
        if (!lock_s)                state_next = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = S_STAGE;
        else                        cnt_next   = cnt + CNT_W'(1);
      end
      S_STAGE: begin
        if (!lock_s)              state_next = S_LOST;
        else if (cnt == GAP_LAST) state_next = S_RUN;
        else                      cnt_next   = cnt + CNT_W'(1);
      end
      S_RUN:   if (!lock_s) state_next = S_LOST;
      S_LOST:  state_next = S_PLL_RST;
      S_FAIL:  state_next = S_FAIL;
      default: state_next = S_PLL_RST;
    endcase

    // Restart overrides every transition above, including the same-cycle
    // STAGE->RUN step and the FAIL trap.
    if (restart_req) begin
      state_next = S_PLL_RST;
      retry_next = 4'd0;
    end

    // Counter clears on every state entry (a restart re-entering PLL_RST included).
    if ((state_next != state) || restart_req) cnt_next = '0;
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the state entry edge with no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      retry_cnt <= 4'd0;
      lock_sync <= 2'b00;
      pll_rst   <= 1'b1;
      rst_core  <= 1'b1;
      rst_video <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      retry_cnt <= retry_next;
      lock_sync <= {lock_sync[0], pll_locked};
      pll_rst   <= (state_next == S_PLL_RST);
      rst_core  <= !((state_next == S_STAGE) || (state_next == S_RUN));
      rst_video <= (state_next != S_RUN);
      ready     <= (state_next == S_RUN);
      fail      <= (state_next == S_FAIL);
    end
  end

endmodule
`default_nettype wire
